// File: rtl/kmeans_sequencer_pkg.sv
// Shared types and constants for the k-means sequencer: FSM states, frame
// geometry, cluster limits and the cold-start seed table.
package kmeans_sequencer_pkg;

   localparam int MAX_BALLS = 7;
   localparam int WIDTH     = 320;
   localparam int HEIGHT    = 180;

   typedef enum logic [1:0] {
      IDLE,
      RESEED,
      CAPTURE,
      CLUSTER
   } state_e;

   typedef logic [MAX_BALLS-1:0][8:0] cent_x_t;
   typedef logic [MAX_BALLS-1:0][7:0] cent_y_t;

   // Cold seeds are spread evenly along the frame's horizontal midline.
   localparam cent_x_t DEFAULT_SEED_X = {9'd280, 9'd240, 9'd200, 9'd160, 9'd120, 9'd80, 9'd40};
   localparam cent_y_t DEFAULT_SEED_Y = {7{8'd90}};

endpackage

// File: rtl/kmeans_sequencer_sanitizer.sv
// Per-centroid range check: keeps the previous result for centroids that fall
// outside the frame and zeroes entries beyond the active cluster count.
module centroid_sanitizer #(
   parameter int WIDTH  = kmeans_sequencer_pkg::WIDTH,
   parameter int HEIGHT = kmeans_sequencer_pkg::HEIGHT
) (
   input  logic [kmeans_sequencer_pkg::MAX_BALLS*9-1:0] raw_x_i,
   input  logic [kmeans_sequencer_pkg::MAX_BALLS*8-1:0] raw_y_i,
   input  logic [kmeans_sequencer_pkg::MAX_BALLS*9-1:0] prev_x_i,
   input  logic [kmeans_sequencer_pkg::MAX_BALLS*8-1:0] prev_y_i,
   input  logic [2:0]                                   num_balls_i,
   output logic [kmeans_sequencer_pkg::MAX_BALLS*9-1:0] clean_x_o,
   output logic [kmeans_sequencer_pkg::MAX_BALLS*8-1:0] clean_y_o
);
   import kmeans_sequencer_pkg::*;

   cent_x_t raw_x, prev_x, clean_x;
   cent_y_t raw_y, prev_y, clean_y;

   // An empty cluster makes the engine divide by zero; hold x and y together
   // so a bad centroid never mixes a fresh coordinate with a stale one.
   always_comb begin
      raw_x   = raw_x_i;
      raw_y   = raw_y_i;
      prev_x  = prev_x_i;
      prev_y  = prev_y_i;
      clean_x = '0;
      clean_y = '0;
      for (int i = 0; i < MAX_BALLS; i++) begin
         if (i < int'(num_balls_i)) begin
            if (int'(raw_x[i]) >= WIDTH || int'(raw_y[i]) >= HEIGHT) begin
               clean_x[i] = prev_x[i];
               clean_y[i] = prev_y[i];
            end else begin
               clean_x[i] = raw_x[i];
               clean_y[i] = raw_y[i];
            end
         end
      end
      clean_x_o = clean_x;
      clean_y_o = clean_y;
   end

endmodule

// File: rtl/kmeans_sequencer.sv
// Frame-level sequencer for an external k-means engine: seeds it, starts one
// clustering run per frame, publishes sanitized centroids and guards with a watchdog.
module kmeans_sequencer #(
   parameter int MAX_BALLS      = kmeans_sequencer_pkg::MAX_BALLS,
   parameter int WIDTH          = kmeans_sequencer_pkg::WIDTH,
   parameter int HEIGHT         = kmeans_sequencer_pkg::HEIGHT,
   parameter int TIMEOUT_CYCLES = 131072
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   enable_in,
   input  logic [2:0]             num_balls_in,
   input  logic                   frame_end_in,
   input  logic                   km_valid_in,
   input  logic [MAX_BALLS*9-1:0] km_x_in,
   input  logic [MAX_BALLS*8-1:0] km_y_in,
   output logic                   km_rst_out,
   output logic                   km_new_frame_out,
   output logic [MAX_BALLS*9-1:0] seed_x_out,
   output logic [MAX_BALLS*8-1:0] seed_y_out,
   output logic [2:0]             num_balls_out,
   output logic [MAX_BALLS*9-1:0] result_x_out,
   output logic [MAX_BALLS*8-1:0] result_y_out,
   output logic                   result_valid_out,
   output logic                   timeout_out,
   output logic [7:0]             dropped_out,
   output logic                   busy_out
);
   import kmeans_sequencer_pkg::*;

   localparam int WD_W = $clog2(TIMEOUT_CYCLES);

   state_e          state_q, state_d;
   logic [2:0]      num_balls_q, num_balls_d, num_req;
   cent_x_t         result_x_q, result_x_d, clean_x, seed_x_q, seed_x;
   cent_y_t         result_y_q, result_y_d, clean_y, seed_y_q, seed_y;
   logic            warm_q, warm_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            reseed_cnt_q, reseed_cnt_d;
   logic            post_reseed_q;
   logic            new_frame_q, new_frame_d;
   logic            valid_q, valid_d;
   logic            timeout_q, timeout_d;
   logic [7:0]      dropped_q, dropped_d;

   assign num_req = (num_balls_in == 3'd0) ? 3'd1 : num_balls_in;

   centroid_sanitizer #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_sanitizer (
      .raw_x_i     (km_x_in),
      .raw_y_i     (km_y_in),
      .prev_x_i    (result_x_q),
      .prev_y_i    (result_y_q),
      .num_balls_i (num_balls_q),
      .clean_x_o   (clean_x),
      .clean_y_o   (clean_y)
   );

   always_comb begin
      state_d      = state_q;
      num_balls_d  = num_balls_q;
      result_x_d   = result_x_q;
      result_y_d   = result_y_q;
      warm_d       = warm_q;
      wd_d         = wd_q;
      reseed_cnt_d = 1'b0;
      new_frame_d  = 1'b0;
      valid_d      = 1'b0;
      timeout_d    = 1'b0;
      dropped_d    = dropped_q;
      if ((state_q == RESEED || state_q == CLUSTER) && frame_end_in && dropped_q != 8'hFF) begin
         dropped_d = dropped_q + 8'd1;
      end
      case (state_q)
         IDLE: begin
            if (enable_in) begin
               state_d     = RESEED;
               num_balls_d = num_req;
            end
         end
         RESEED: begin
            if (reseed_cnt_q) begin
               state_d = CAPTURE;
            end else begin
               reseed_cnt_d = 1'b1;
            end
         end
         CAPTURE: begin
            if (frame_end_in) begin
               if (!enable_in) begin
                  state_d = IDLE;
               end else if (num_req != num_balls_q) begin
                  state_d     = RESEED;
                  warm_d      = 1'b0;
                  num_balls_d = num_req;
               end else begin
                  state_d     = CLUSTER;
                  new_frame_d = 1'b1;
                  wd_d        = '0;
               end
            end
         end
         CLUSTER: begin
            // A result arriving on the last watchdog cycle still counts.
            wd_d = wd_q + WD_W'(1);
            if (km_valid_in) begin
               state_d    = CAPTURE;
               result_x_d = clean_x;
               result_y_d = clean_y;
               valid_d    = 1'b1;
               warm_d     = 1'b1;
            end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
               state_d   = RESEED;
               timeout_d = 1'b1;
               warm_d    = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Seeds look ahead at the next warm flag so they settle the cycle before
   // RESEED, then freeze through RESEED and the first CAPTURE cycle.
   always_comb begin
      seed_x = warm_d ? result_x_q : DEFAULT_SEED_X;
      seed_y = warm_d ? result_y_q : DEFAULT_SEED_Y;
      if (state_q == RESEED || post_reseed_q) begin
         seed_x = seed_x_q;
         seed_y = seed_y_q;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q       <= IDLE;
         num_balls_q   <= 3'd1;
         result_x_q    <= '0;
         result_y_q    <= '0;
         seed_x_q      <= DEFAULT_SEED_X;
         seed_y_q      <= DEFAULT_SEED_Y;
         warm_q        <= 1'b0;
         wd_q          <= '0;
         reseed_cnt_q  <= 1'b0;
         post_reseed_q <= 1'b0;
         new_frame_q   <= 1'b0;
         valid_q       <= 1'b0;
         timeout_q     <= 1'b0;
         dropped_q     <= 8'd0;
      end else begin
         state_q       <= state_d;
         num_balls_q   <= num_balls_d;
         result_x_q    <= result_x_d;
         result_y_q    <= result_y_d;
         seed_x_q      <= seed_x;
         seed_y_q      <= seed_y;
         warm_q        <= warm_d;
         wd_q          <= wd_d;
         reseed_cnt_q  <= reseed_cnt_d;
         post_reseed_q <= (state_q == RESEED) && (state_d == CAPTURE);
         new_frame_q   <= new_frame_d;
         valid_q       <= valid_d;
         timeout_q     <= timeout_d;
         dropped_q     <= dropped_d;
      end
   end

   assign km_rst_out       = (state_q == RESEED);
   assign km_new_frame_out = new_frame_q;
   assign seed_x_out       = seed_x;
   assign seed_y_out       = seed_y;
   assign num_balls_out    = num_balls_q;
   assign result_x_out     = result_x_q;
   assign result_y_out     = result_y_q;
   assign result_valid_out = valid_q;
   assign timeout_out      = timeout_q;
   assign dropped_out      = dropped_q;
   assign busy_out         = (state_q == RESEED) || (state_q == CLUSTER);

endmodule
